// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index 0 is the rightmost 7-bit field.
    localparam logic [15:0][6:0] SEG_HEX_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef struct packed {
        logic [3:0] nibble;
        logic [6:0] raw;
        logic       raw_en;
        logic       dp;
        logic       blank;
    } digit_shadow_t;

    localparam digit_shadow_t SHADOW_RST = '{
        nibble: 4'h0, raw: 7'h00, raw_en: 1'b0, dp: 1'b0, blank: 1'b1
    };

    function automatic logic [6:0] seg7_hex(input logic [3:0] nib);
        return SEG_HEX_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_lzs_mask.sv
// Leading-zero suppression mask: marks hex-mode zero digits above the most
// significant digit that is non-zero or in raw mode. Digit 0 is never suppressed.
module seg7_lzs_mask #(
    parameter int NUM_DIGITS = 4
) (
    input  logic [4*NUM_DIGITS-1:0] nibbles_i,
    input  logic [NUM_DIGITS-1:0]   raw_en_i,
    input  logic                    lzs_en_i,
    output logic [NUM_DIGITS-1:0]   suppress_o
);

    always_comb begin
        logic leading;
        leading    = lzs_en_i;
        suppress_o = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (leading && !raw_en_i[i] && (nibbles_i[4*i +: 4] == 4'h0)) begin
                suppress_o[i] = 1'b1;
            end else begin
                leading = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with PWM brightness, dead time
// between digits and frame-synchronous shadow updates.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int BRIGHT_W   = 4,
    parameter int DEAD_CYC   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [7*NUM_DIGITS-1:0] raw_seg,
    input  logic [NUM_DIGITS-1:0]   raw_en,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lzs_en,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick
);

    localparam int          DIGIT_CYC   = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int          SLOT_W      = $clog2(DIGIT_CYC);
    localparam int          IDX_W       = $clog2(NUM_DIGITS);
    localparam logic [31:0] DIGIT_CYC_W = 32'(DIGIT_CYC);
    localparam logic [31:0] DEAD_LIM    = 32'(DEAD_CYC);

    if (DIGIT_CYC <= DEAD_CYC || DIGIT_CYC < 2) begin : g_bad_timing
        $error("seg7_scan_ctrl: digit slot must exceed the dead time and be at least 2 cycles");
    end
    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("seg7_scan_ctrl: NUM_DIGITS must be in 2..8");
    end

    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]  digit_idx_q, digit_idx_d;

    digit_shadow_t [NUM_DIGITS-1:0] act_q, act_d, pend_q, pend_d, load_shadow;
    logic act_lzs_q, act_lzs_d, pend_lzs_q, pend_lzs_d, pend_flag_q, pend_flag_d;

    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d, frame_tick_q, frame_tick_d;

    logic                    slot_wrap, frame_wrap;
    logic [4*NUM_DIGITS-1:0] act_nibbles;
    logic [NUM_DIGITS-1:0]   act_raw_en, suppress;
    logic [31:0]             on_end, slot_ext;
    digit_shadow_t           cur;

    always_comb begin
        act_nibbles = '0;
        act_raw_en  = '0;
        load_shadow = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            act_nibbles[4*i +: 4] = act_q[i].nibble;
            act_raw_en[i]         = act_q[i].raw_en;
            load_shadow[i]        = '{nibble: value[4*i +: 4], raw: raw_seg[7*i +: 7],
                                      raw_en: raw_en[i], dp: dp_in[i], blank: blank[i]};
        end
    end

    seg7_lzs_mask #(.NUM_DIGITS(NUM_DIGITS)) u_lzs (
        .nibbles_i  (act_nibbles),
        .raw_en_i   (act_raw_en),
        .lzs_en_i   (act_lzs_q),
        .suppress_o (suppress)
    );

    always_comb begin
        slot_wrap  = (slot_cnt_q == SLOT_W'(DIGIT_CYC - 1));
        frame_wrap = slot_wrap && (digit_idx_q == IDX_W'(NUM_DIGITS - 1));

        slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (slot_wrap) begin
            digit_idx_d = frame_wrap ? '0 : digit_idx_q + 1'b1;
        end

        // Boundary swap is applied before the load so a load in the boundary
        // cycle becomes the next pending frame rather than being dropped.
        act_d       = act_q;
        act_lzs_d   = act_lzs_q;
        pend_d      = pend_q;
        pend_lzs_d  = pend_lzs_q;
        pend_flag_d = pend_flag_q;
        if (frame_wrap && pend_flag_q) begin
            act_d       = pend_q;
            act_lzs_d   = pend_lzs_q;
            pend_flag_d = 1'b0;
        end
        if (load) begin
            pend_d      = load_shadow;
            pend_lzs_d  = lzs_en;
            pend_flag_d = 1'b1;
        end

        on_end   = ((32'(brightness) + 32'd1) * DIGIT_CYC_W) >> BRIGHT_W;
        slot_ext = 32'(slot_cnt_q);
        an_d     = '1;
        if (slot_ext >= DEAD_LIM && slot_ext < on_end) begin
            an_d = ~(NUM_DIGITS'(1) << digit_idx_q);
        end

        cur = act_q[digit_idx_q];
        if (cur.blank) begin
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end else begin
            dp_d = ~cur.dp;
            if (suppress[digit_idx_q]) begin
                seg_d = SEG_BLANK;
            end else if (cur.raw_en) begin
                seg_d = cur.raw;
            end else begin
                seg_d = seg7_hex(cur.nibble);
            end
        end

        frame_tick_d = frame_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt_q   <= '0;
            digit_idx_q  <= '0;
            act_q        <= {NUM_DIGITS{SHADOW_RST}};
            pend_q       <= {NUM_DIGITS{SHADOW_RST}};
            act_lzs_q    <= 1'b0;
            pend_lzs_q   <= 1'b0;
            pend_flag_q  <= 1'b0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            digit_idx_q  <= digit_idx_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
            act_lzs_q    <= act_lzs_d;
            pend_lzs_q   <= pend_lzs_d;
            pend_flag_q  <= pend_flag_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a cycle-count reference model queues the
// expected outputs per clock, an independent monitor pops and compares them.
module tb_seg7_scan_ctrl;

    localparam int ND    = 4;
    localparam int DC    = 64;
    localparam int DEAD  = 2;
    localparam int FRAME = DC * ND;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [27:0] raw_seg = '0;
    logic [3:0]  raw_en = '0, dp_in = '0, blank = '0;
    logic        lzs_en = 1'b0;
    logic [3:0]  brightness = 4'hF;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp, frame_tick;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .NUM_DIGITS(ND), .CLK_HZ(64000), .REFRESH_HZ(250), .BRIGHT_W(4), .DEAD_CYC(DEAD)
    ) dut (
        .clk(clk), .rst(rst), .load(load), .value(value), .raw_seg(raw_seg),
        .raw_en(raw_en), .dp_in(dp_in), .blank(blank), .lzs_en(lzs_en),
        .brightness(brightness), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state: cycles since reset plus displayed / pending frames.
    int         m_n = 0;
    logic       m_pflag = 0;
    logic [3:0] a_nib[ND], p_nib[ND];
    logic [6:0] a_raw[ND], p_raw[ND];
    logic       a_ren[ND], p_ren[ND], a_dp[ND], p_dp[ND], a_blk[ND], p_blk[ND];
    logic       a_lzs = 0, p_lzs = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, req);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_pflag = 0; a_lzs = 0; p_lzs = 0;
        for (int i = 0; i < ND; i++) begin
            a_nib[i] = 0; a_raw[i] = 0; a_ren[i] = 0; a_dp[i] = 0; a_blk[i] = 1;
            p_nib[i] = 0; p_raw[i] = 0; p_ren[i] = 0; p_dp[i] = 0; p_blk[i] = 1;
        end
    endtask

    task automatic model_eval();
        exp_t e;
        int slot, dig, on_end, top;
        logic found;
        if (rst) begin
            e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, ft: 1'b0};
            model_reset();
        end else begin
            slot   = m_n % DC;
            dig    = (m_n / DC) % ND;
            on_end = ((int'(brightness) + 1) * DC) / 16;
            e.an   = (slot >= DEAD && slot < on_end) ? ~(4'b0001 << dig) : 4'hF;
            top = 0; found = 0;
            for (int i = ND - 1; i >= 1; i--) begin
                if (!found && (a_nib[i] != 0 || a_ren[i])) begin
                    top = i; found = 1;
                end
            end
            if (a_blk[dig]) begin
                e.seg = 7'h7F; e.dp = 1'b1;
            end else begin
                e.dp = ~a_dp[dig];
                if (a_lzs && dig > top) e.seg = 7'h7F;
                else if (a_ren[dig])    e.seg = a_raw[dig];
                else                    e.seg = hex_tab[a_nib[dig]];
            end
            e.ft = (m_n % FRAME == FRAME - 1);
            if (e.ft && m_pflag) begin
                a_nib = p_nib; a_raw = p_raw; a_ren = p_ren; a_dp = p_dp; a_blk = p_blk;
                a_lzs = p_lzs; m_pflag = 0;
            end
            if (load) begin
                for (int i = 0; i < ND; i++) begin
                    p_nib[i] = value[4*i +: 4]; p_raw[i] = raw_seg[7*i +: 7];
                    p_ren[i] = raw_en[i]; p_dp[i] = dp_in[i]; p_blk[i] = blank[i];
                end
                p_lzs = lzs_en; m_pflag = 1;
            end
            m_n = (m_n + 1) % FRAME;
        end
        exp_q.push_back(e);
    endtask

    task automatic step();
        model_eval();
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                           input logic [3:0] re, input logic [27:0] rs, input logic lz);
        value = v; dp_in = d; blank = b; raw_en = re; raw_seg = rs; lzs_en = lz;
        load = 1'b1;
        step();
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (m_n != target && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        check("run_to_bound", 32'(m_n), 32'(target));
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("an", 32'(an), 32'(e.an));
            check("seg", 32'(seg), 32'(e.seg));
            check("dp", 32'(dp), 32'(e.dp));
            check("frame_tick", 32'(frame_tick), 32'(e.ft));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(negedge clk);
        run(3);
        rst = 1'b0;
        run(2 * FRAME);

        do_load(16'h12AF, 4'b0000, 4'b0000, 4'b0000, 28'h0, 1'b0);
        run(2 * FRAME);
        brightness = 4'd7;
        run(FRAME);
        brightness = 4'd0;
        run(FRAME);
        brightness = 4'hF;

        do_load(16'h0040, 4'b1000, 4'b0000, 4'b0000, 28'h0, 1'b1);
        run(2 * FRAME);
        do_load(16'h0000, 4'b0000, 4'b0000, 4'b0000, 28'h0, 1'b1);
        run(2 * FRAME);
        do_load(16'h0000, 4'b0011, 4'b0000, 4'b0100, 28'h2A5_5A5A, 1'b1);
        run(FRAME + 40);

        run_to(100);
        do_load(16'hAAAA, 4'b0001, 4'b0000, 4'b0000, 28'h0, 1'b0);
        run_to(FRAME - 2);
        do_load(16'hBBBB, 4'b0010, 4'b0000, 4'b0000, 28'h0, 1'b0);
        do_load(16'hCCCC, 4'b0100, 4'b0001, 4'b0000, 28'h0, 1'b0);
        run(2 * FRAME + 20);

        run_to(DC + 11);
        #2;
        check("an_before_rst", 32'(an), 32'(4'b1101));
        rst = 1'b1;
        #1;
        check("an_async_rst", 32'(an), 32'(4'hF));
        check("seg_async_rst", 32'(seg), 32'(7'h7F));
        check("dp_async_rst", 32'(dp), 32'(1'b1));
        @(negedge clk);
        run(2);
        rst = 1'b0;
        run(2 * FRAME);

        repeat (4000) begin
            if ($urandom_range(0, 149) == 0)
                brightness = 4'($urandom);
            if ($urandom_range(0, 99) == 0)
                do_load(16'($urandom) >> (4 * $urandom_range(0, 4)), 4'($urandom),
                        4'($urandom & $urandom), 4'($urandom & $urandom),
                        28'($urandom), 1'($urandom));
            else
                step();
        end
        run(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
